// File: rtl/bsa_pkg.sv
// Shared definitions for the byte-serial adder: byte width, control FSM
// state encoding and the byte-index width helper.
package bsa_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte index width: clog2(nbytes), never narrower than one bit.
   function automatic int idx_width(input int nbytes);
      return (nbytes <= 2) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/byte_serial_adder_if.sv
// Operand/result handshake bundle for byte_serial_adder.
// Optional macro SIGNED_OVF_EN adds the ovf signal to the bundle.
interface byte_serial_adder_if #(
   parameter int NBYTES = 4
);
   import bsa_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [BYTE_W*NBYTES-1:0] a_in;
   logic [BYTE_W*NBYTES-1:0] b_in;
   logic                     cin;
   logic                     out_valid;
   logic                     out_ready;
   logic [BYTE_W*NBYTES-1:0] sum_out;
   logic                     cout;
`ifdef SIGNED_OVF_EN
   logic                     ovf;

   modport master (
      output in_valid, a_in, b_in, cin, out_ready,
      input  in_ready, out_valid, sum_out, cout, ovf
   );

   modport slave (
      input  in_valid, a_in, b_in, cin, out_ready,
      output in_ready, out_valid, sum_out, cout, ovf
   );
`else
   modport master (
      output in_valid, a_in, b_in, cin, out_ready,
      input  in_ready, out_valid, sum_out, cout
   );

   modport slave (
      input  in_valid, a_in, b_in, cin, out_ready,
      output in_ready, out_valid, sum_out, cout
   );
`endif

endinterface

// File: rtl/Carry_Look_Ahead_Adder_8bit.sv
// 8-bit carry look-ahead adder: every carry is built directly from the
// generate/propagate terms and c0, so no carry ripples through the byte.
module Carry_Look_Ahead_Adder_8bit
   import bsa_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              c0,
   output logic [BYTE_W-1:0] s,
   output logic              c8
);

   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0 for every bit.
   always_comb begin
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < BYTE_W; i++) begin
         logic cy;
         logic pr;
         cy = g[i];
         pr = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            cy = cy | (pr & g[j]);
            pr = pr & p[j];
         end
         c[i+1] = cy | (pr & c0);
      end
   end

   assign s  = p ^ c[BYTE_W-1:0];
   assign c8 = c[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder built from one 8-bit CLA used once per cycle, LSB byte first,
// with the byte carry-out fed back as the next byte's carry-in.
// Optional macro SIGNED_OVF_EN adds a registered signed-overflow flag (ovf).
module byte_serial_adder
   import bsa_pkg::*;
#(
   parameter int NBYTES = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   byte_serial_adder_if.slave  bus
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = idx_width(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic [W-1:0]       sum_reg;
   logic               cout_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic [BYTE_W-1:0]  a_byte;
   logic [BYTE_W-1:0]  b_byte;
   logic [BYTE_W-1:0]  s_byte;
   logic               c8;
`ifdef SIGNED_OVF_EN
   logic               ovf_reg;
`endif

   // Present the operand byte slices selected by the current index.
   always_comb begin
      a_byte = a_reg[BYTE_W*int'(idx) +: BYTE_W];
      b_byte = b_reg[BYTE_W*int'(idx) +: BYTE_W];
   end

   Carry_Look_Ahead_Adder_8bit u_cla (
      .a  (a_byte),
      .b  (b_byte),
      .c0 (carry),
      .s  (s_byte),
      .c8 (c8)
   );

   // Control FSM, byte index, carry chain and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         idx           <= '0;
         carry         <= 1'b0;
         sum_reg       <= '0;
         cout_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
`ifdef SIGNED_OVF_EN
         ovf_reg       <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_reg) begin
                  a_reg        <= bus.a_in;
                  b_reg        <= bus.b_in;
                  carry        <= bus.cin;
                  idx          <= '0;
                  sum_reg      <= '0;
                  cout_reg     <= 1'b0;
                  in_ready_reg <= 1'b0;
                  state        <= ST_ADD;
               end
            end
            ST_ADD: begin
               sum_reg[BYTE_W*int'(idx) +: BYTE_W] <= s_byte;
               carry <= c8;
               if (idx == LAST_IDX) begin
                  // Index is parked at zero so it never runs past the top byte.
                  idx           <= '0;
                  cout_reg      <= c8;
                  out_valid_reg <= 1'b1;
                  state         <= ST_DONE;
`ifdef SIGNED_OVF_EN
                  ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (s_byte[BYTE_W-1] != a_reg[W-1]);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state         <= ST_IDLE;
`ifdef SIGNED_OVF_EN
                  ovf_reg       <= 1'b0;
`endif
               end
            end
            default: begin
               state         <= ST_IDLE;
               idx           <= '0;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.sum_out   = sum_reg;
   assign bus.cout      = cout_reg;
`ifdef SIGNED_OVF_EN
   assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (NBYTES=4 and NBYTES=1 instances).
// Honors SIGNED_OVF_EN for the ovf checks.
module tb_byte_serial_adder;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   byte_serial_adder_if #(.NBYTES(4)) bus4 ();
   byte_serial_adder_if #(.NBYTES(1)) bus1 ();

   byte_serial_adder #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   byte_serial_adder #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Golden model: plain integer addition, result {ovf, cout, sum}.
   function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic c);
      logic [32:0] t;
      t = {1'b0, a} + {1'b0, b} + {32'd0, c};
      return {(a[31] == b[31]) && (t[31] != a[31]), t};
   endfunction

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, b} + {8'd0, c};
      return {(a[7] == b[7]) && (t[7] != a[7]), t};
   endfunction

   // One transaction on the 4-byte instance; reports result, latency and whether in_ready stayed low.
   task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] s, output logic co, output logic o,
                       output int lat, output bit rdy_low);
      int guard;
      @(negedge clk);
      bus4.a_in = a; bus4.b_in = b; bus4.cin = c; bus4.in_valid = 1'b1;
      guard = 0;
      while (!bus4.in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      bus4.a_in = $urandom; bus4.b_in = $urandom; bus4.cin = 1'($urandom);
      lat = 0; rdy_low = 1'b1;
      while (lat < 20) begin
         if (bus4.in_ready) rdy_low = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (bus4.out_valid) break;
      end
      if (bus4.in_ready) rdy_low = 1'b0;
      s = bus4.sum_out; co = bus4.cout;
`ifdef SIGNED_OVF_EN
      o = bus4.ovf;
`else
      o = 1'b0;
`endif
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
   endtask

   // Back-to-back random stream on the 4-byte instance, scoreboard in a queue.
   task automatic stream4(input int n);
      logic [33:0] q[$];
      int          acc_cyc[$];
      logic [33:0] e;
      int sent, got, cyc, last_hs;
      bit acc, hs;
      sent = 0; got = 0; cyc = 0; last_hs = -10;
      @(negedge clk);
      bus4.out_ready = 1'b1;
      bus4.a_in = $urandom; bus4.b_in = $urandom; bus4.cin = 1'($urandom);
      bus4.in_valid = 1'b1;
      for (int guard = 0; guard < 2000 && got < n; guard++) begin
         acc = bus4.in_valid && bus4.in_ready;
         hs  = bus4.out_valid && bus4.out_ready;
         if (hs) begin
            check("s4_result_expected", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("s4_sum", bus4.sum_out, e[31:0]);
               check("s4_cout", bus4.cout, e[32]);
`ifdef SIGNED_OVF_EN
               check("s4_ovf", bus4.ovf, e[33]);
`endif
               check("s4_latency", cyc - acc_cyc.pop_front(), 5);
            end
            last_hs = cyc;
            got++;
         end
         if (acc) begin
            if (sent > 0) check("s4_b2b_gap", cyc, last_hs + 1);
            q.push_back(model32(bus4.a_in, bus4.b_in, bus4.cin));
            acc_cyc.push_back(cyc);
            sent++;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (sent < n) begin
               bus4.a_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
               bus4.b_in = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
               bus4.cin  = 1'($urandom);
            end else begin
               bus4.in_valid = 1'b0;
            end
         end
      end
      check("s4_all_results", got, n);
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b0;
   endtask

   // Back-to-back random stream on the single-byte instance.
   task automatic stream1(input int n);
      logic [9:0] q[$];
      int         acc_cyc[$];
      logic [9:0] e;
      int sent, got, cyc;
      bit acc, hs;
      sent = 0; got = 0; cyc = 0;
      @(negedge clk);
      bus1.out_ready = 1'b1;
      bus1.a_in = 8'($urandom); bus1.b_in = 8'($urandom); bus1.cin = 1'($urandom);
      bus1.in_valid = 1'b1;
      for (int guard = 0; guard < 1000 && got < n; guard++) begin
         acc = bus1.in_valid && bus1.in_ready;
         hs  = bus1.out_valid && bus1.out_ready;
         if (hs) begin
            check("s1_result_expected", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("s1_sum", bus1.sum_out, e[7:0]);
               check("s1_cout", bus1.cout, e[8]);
`ifdef SIGNED_OVF_EN
               check("s1_ovf", bus1.ovf, e[9]);
`endif
               check("s1_latency", cyc - acc_cyc.pop_front(), 2);
            end
            got++;
         end
         if (acc) begin
            q.push_back(model8(bus1.a_in, bus1.b_in, bus1.cin));
            acc_cyc.push_back(cyc);
            sent++;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (sent < n) begin
               bus1.a_in = 8'($urandom);
               bus1.b_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
               bus1.cin  = 1'($urandom);
            end else begin
               bus1.in_valid = 1'b0;
            end
         end
      end
      check("s1_all_results", got, n);
      bus1.in_valid = 1'b0;
      bus1.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] s;
      logic        co;
      logic        o;
      int          lat;
      bit          rdy_low;
      bit          no_result;

      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
      vecs[7] = '{32'h80FF_7F01, 32'h7F00_807E, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};

      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.cin = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus4.out_valid, 0);
      check("rst_sum", bus4.sum_out, 0);
      check("rst_cout", bus4.cout, 0);
      check("rst_in_ready", bus4.in_ready, 1);
      check("rst1_out_valid", bus1.out_valid, 0);
      check("rst1_in_ready", bus1.in_ready, 1);
`ifdef SIGNED_OVF_EN
      check("rst_ovf", bus4.ovf, 0);
`endif
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         run4(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, o, lat, rdy_low);
         check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
`ifdef SIGNED_OVF_EN
         check($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
`endif
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_in_ready_low", i), rdy_low, 1);
         check($sformatf("vec%0d_idle_out_valid", i), bus4.out_valid, 0);
         check($sformatf("vec%0d_idle_in_ready", i), bus4.in_ready, 1);
      end

      // Result held under back-pressure, new operands ignored
      @(negedge clk);
      bus4.a_in = 32'h0000_00FF; bus4.b_in = 32'h0000_0001; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.a_in = 32'hFFFF_FFFF; bus4.b_in = 32'hFFFF_FFFF; bus4.cin = 1'b1;
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold_latency", lat, 4);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_out_valid", k), bus4.out_valid, 1);
         check($sformatf("hold%0d_sum", k), bus4.sum_out, 32'h0000_0100);
         check($sformatf("hold%0d_cout", k), bus4.cout, 0);
         check($sformatf("hold%0d_in_ready", k), bus4.in_ready, 0);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
      check("hold_release_in_ready", bus4.in_ready, 1);
      check("hold_release_out_valid", bus4.out_valid, 0);

      // Reset mid-ADD aborts the transaction
      @(negedge clk);
      bus4.a_in = 32'hFFFF_FFFF; bus4.b_in = 32'h0000_0001; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_out_valid", bus4.out_valid, 0);
      check("abort_sum", bus4.sum_out, 0);
      check("abort_cout", bus4.cout, 0);
      check("abort_in_ready", bus4.in_ready, 1);
      rst_n = 1'b1;
      no_result = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus4.out_valid) no_result = 1'b0;
      end
      check("abort_no_result", no_result, 1);
      bus4.out_ready = 1'b0;

      // Back-to-back random streams
      stream4(40);
      stream1(40);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
